// File: rtl/open_list_arbiter.sv
// open_list_arbiter: round-robin sequencer sharing one systolic min-priority open-list queue between NUM_REQ requesters
// Ports:
//   CLK, RST                      clock, asynchronous active-high reset
//   req_valid/req_op/req_data     per-requester request (op 01 push, 10 pop, 11 replace, 00 no-op)
//   req_ready                     one-hot grant, combinational in IDLE
//   resp_valid/resp_data/resp_err one-hot completion pulse with head value or error
//   q_wrt/q_read/q_node_f         queue strobes and data in, driven only in ISSUE
//   q_full/q_empty/q_head_f       queue status and current minimum
//   busy                          operation in flight
module open_list_arbiter #(
   parameter int NUM_REQ       = 4,
   parameter int DATA_WIDTH    = 32,
   parameter int SETTLE_CYCLES = 1
) (
   input  logic                          CLK,
   input  logic                          RST,
   input  logic [NUM_REQ-1:0]            req_valid,
   input  logic [2*NUM_REQ-1:0]          req_op,
   input  logic [DATA_WIDTH*NUM_REQ-1:0] req_data,
   output logic [NUM_REQ-1:0]            req_ready,
   output logic [NUM_REQ-1:0]            resp_valid,
   output logic [DATA_WIDTH-1:0]         resp_data,
   output logic                          resp_err,
   output logic                          q_wrt,
   output logic                          q_read,
   output logic [DATA_WIDTH-1:0]         q_node_f,
   input  logic                          q_full,
   input  logic                          q_empty,
   input  logic [DATA_WIDTH-1:0]         q_head_f,
   output logic                          busy
);
   localparam int IW = NUM_REQ > 1 ? $clog2(NUM_REQ) : 1;
   localparam int CW = SETTLE_CYCLES > 1 ? $clog2(SETTLE_CYCLES + 1) : 1;
   typedef enum logic [1:0] {IDLE, ISSUE, SETTLE} state_t;
   state_t          st;
   logic [IW-1:0]   rr_ptr, win, who;
   logic [1:0]      op;
   logic [CW-1:0]   cnt;
   logic            any, is_push, is_pop;
   // scan downward so the lowest offset from rr_ptr is the final assignment
   always_comb begin
      win = '0;
      any = 1'b0;
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         if (req_valid[(int'(rr_ptr) + i) % NUM_REQ]) begin
            win = IW'((int'(rr_ptr) + i) % NUM_REQ);
            any = 1'b1;
         end
      end
   end
   assign req_ready = (st == IDLE && any && !RST) ? (NUM_REQ'(1) << win) : '0;
   assign is_push   = op == 2'b01;
   assign is_pop    = op == 2'b10;
   // strobes decode from state so an asynchronous reset cuts them off at once
   assign q_wrt     = st == ISSUE && op[0] && !(is_push && q_full);
   assign q_read    = st == ISSUE && op[1] && !(is_pop && q_empty);
   assign busy      = st != IDLE;
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         st         <= IDLE;
         rr_ptr     <= '0;
         cnt        <= '0;
         who        <= '0;
         op         <= '0;
         q_node_f   <= '0;
         resp_valid <= '0;
         resp_data  <= '1;
         resp_err   <= 1'b0;
      end else begin
         resp_valid <= '0;
         if (st == IDLE && any) begin
            who      <= win;
            op       <= req_op[2*int'(win) +: 2];
            q_node_f <= req_data[DATA_WIDTH*int'(win) +: DATA_WIDTH];
            rr_ptr   <= IW'((int'(win) + 1) % NUM_REQ);
            st       <= ISSUE;
         end else if (st == ISSUE) begin
            resp_valid[who] <= 1'b1;
            resp_err        <= (is_push && q_full) || (is_pop && q_empty);
            // only pop/replace on a non-empty queue return a real head
            resp_data       <= (op[1] && !q_empty) ? q_head_f : '1;
            cnt             <= CW'(SETTLE_CYCLES - 1);
            st              <= SETTLE;
         end else if (st == SETTLE) begin
            cnt <= cnt - CW'(1);
            if (cnt == '0) st <= IDLE;
         end
      end
   end
endmodule

// File: tb/tb_open_list_arbiter.sv
// tb_open_list_arbiter: directed and randomized check of open_list_arbiter against a transaction-level model and a sorted-queue model
module tb_open_list_arbiter;
   localparam int N = 4, DW = 32, S = 1, DEPTH = 8;
   logic CLK = 0, RST;
   logic [N-1:0] req_valid, req_ready, resp_valid;
   logic [2*N-1:0] req_op;
   logic [DW*N-1:0] req_data;
   logic [DW-1:0] resp_data, q_node_f, q_head_f;
   logic resp_err, q_wrt, q_read, q_full, q_empty, busy;
   open_list_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .SETTLE_CYCLES(S)) dut (
      .CLK(CLK), .RST(RST), .req_valid(req_valid), .req_op(req_op), .req_data(req_data),
      .req_ready(req_ready), .resp_valid(resp_valid), .resp_data(resp_data), .resp_err(resp_err),
      .q_wrt(q_wrt), .q_read(q_read), .q_node_f(q_node_f), .q_full(q_full), .q_empty(q_empty),
      .q_head_f(q_head_f), .busy(busy));
   always #5 CLK = ~CLK;
   int errors = 0, checks = 0;
   logic [DW-1:0] mq[$];
   logic [N-1:0] sv, last_ready;
   logic [2*N-1:0] sop;
   logic [DW*N-1:0] sd;
   bit sfull;
   int cyc, ptr, free_at, g_t, gw;
   bit g_valid, rerr;
   logic [1:0] gop;
   logic [DW-1:0] gd, node_last, rdata;
   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
      end
   endtask
   function automatic int min_idx();
      int m = 0;
      for (int i = 1; i < mq.size(); i++) if (mq[i] < mq[m]) m = i;
      return m;
   endfunction
   task automatic step();
      logic [N-1:0] er, erv;
      logic ew, erd, eb;
      int w;
      @(negedge CLK);
      req_valid = sv; req_op = sop; req_data = sd;
      q_full = sfull || mq.size() >= DEPTH;
      q_empty = mq.size() == 0;
      q_head_f = mq.size() > 0 ? mq[min_idx()] : '0;
      #1;
      eb = cyc < free_at;
      er = '0; w = 0;
      if (!eb && sv != 0) begin
         for (int i = N - 1; i >= 0; i--) if (sv[(ptr + i) % N]) w = (ptr + i) % N;
         er[w] = 1'b1;
      end
      ew = 0; erd = 0;
      if (g_valid && cyc == g_t + 1) begin
         ew = (gop == 2'b01 && !q_full) || gop == 2'b11;
         erd = (gop == 2'b10 && mq.size() > 0) || gop == 2'b11;
         node_last = gd;
         rerr = (gop == 2'b01 && q_full) || (gop == 2'b10 && mq.size() == 0);
         rdata = (gop[1] && mq.size() > 0) ? mq[min_idx()] : 32'hFFFF_FFFF;
      end
      erv = (g_valid && cyc == g_t + 2) ? N'(1) << gw : '0;
      chk("req_ready", req_ready, er);
      chk("q_wrt", q_wrt, ew);
      chk("q_read", q_read, erd);
      chk("q_node_f", q_node_f, node_last);
      chk("resp_valid", resp_valid, erv);
      chk("busy", busy, eb);
      if (erv != 0) begin
         chk("resp_data", resp_data, rdata);
         chk("resp_err", resp_err, rerr);
      end
      if (er != 0) begin
         g_valid = 1; g_t = cyc; gw = w;
         gop = sop[2*w +: 2]; gd = sd[DW*w +: DW];
         ptr = (w + 1) % N; free_at = cyc + 2 + S;
      end
      if (erd && mq.size() > 0) mq.delete(min_idx());
      if (ew) mq.push_back(gd);
      last_ready = er;
      cyc++;
   endtask
   task automatic go(input logic [N-1:0] v, input logic [1:0] o, input logic [DW-1:0] d, input bit f);
      sv = v; sop = {N{o}}; sd = {N{d}}; sfull = f;
      step();
   endtask
   task automatic blk(input string tag, input logic [N-1:0] v, input logic [1:0] o, input logic [DW-1:0] d,
                      input bit f, input logic [DW-1:0] xd, input bit xe, input bit xw, input bit xr);
      go(v, o, d, f);
      chk({tag, "_grant"}, req_ready, v);
      go('0, o, d, f);
      chk({tag, "_wrt"}, q_wrt, xw);
      chk({tag, "_read"}, q_read, xr);
      chk({tag, "_node"}, q_node_f, d);
      go('0, o, d, f);
      chk({tag, "_rv"}, resp_valid, v);
      chk({tag, "_rdata"}, resp_data, xd);
      chk({tag, "_rerr"}, resp_err, xe);
   endtask
   logic [N-1:0] hv;
   logic [1:0] hop[N];
   logic [DW-1:0] hd[N];
   initial begin
      RST = 1; sv = '0; sop = '0; sd = '0; sfull = 0; last_ready = '0; hv = '0;
      req_valid = '0; req_op = '0; req_data = '0; q_full = 0; q_empty = 1; q_head_f = '0;
      cyc = 0; ptr = 0; free_at = 0; g_t = 0; gw = 0; g_valid = 0; rerr = 0;
      gop = '0; gd = '0; node_last = '0; rdata = '1;
      repeat (2) @(negedge CLK);
      #1;
      chk("rst_ready", req_ready, 0);
      chk("rst_rv", resp_valid, 0);
      chk("rst_wrt", q_wrt, 0);
      chk("rst_read", q_read, 0);
      chk("rst_rdata", resp_data, 32'hFFFF_FFFF);
      chk("rst_rerr", resp_err, 0);
      chk("rst_node", q_node_f, 0);
      chk("rst_busy", busy, 0);
      RST = 0;
      blk("push10",  4'b0001, 2'b01, 32'h10, 0, 32'hFFFF_FFFF, 0, 1, 0);
      blk("pop10",   4'b0001, 2'b10, 32'h0,  0, 32'h10,        0, 0, 1);
      blk("popempty",4'b0010, 2'b10, 32'h0,  0, 32'hFFFF_FFFF, 1, 0, 0);
      blk("pushfull",4'b0100, 2'b01, 32'h33, 1, 32'hFFFF_FFFF, 1, 0, 0);
      blk("push9",   4'b1000, 2'b01, 32'h9,  0, 32'hFFFF_FFFF, 0, 1, 0);
      blk("push5",   4'b0001, 2'b01, 32'h5,  0, 32'hFFFF_FFFF, 0, 1, 0);
      blk("repl7",   4'b0010, 2'b11, 32'h7,  0, 32'h5,         0, 1, 1);
      blk("pop7",    4'b0100, 2'b10, 32'h0,  0, 32'h7,         0, 0, 1);
      go(4'b0010, 2'b01, 32'h44, 0);
      chk("rstmid_grant", req_ready, 4'b0010);
      sv = '0;
      @(negedge CLK);
      req_valid = '0;
      #1;
      chk("rstmid_pre_wrt", q_wrt, 1);
      RST = 1;
      #1;
      chk("rstmid_wrt", q_wrt, 0);
      chk("rstmid_read", q_read, 0);
      chk("rstmid_busy", busy, 0);
      chk("rstmid_ready", req_ready, 0);
      @(negedge CLK);
      #1;
      chk("rstmid_rv", resp_valid, 0);
      chk("rstmid_node", q_node_f, 0);
      RST = 0;
      cyc += 2; g_valid = 0; free_at = 0; ptr = 0; node_last = '0;
      go('0, 2'b00, 32'h0, 0);
      for (int k = 0; k < 13; k++) begin
         go(4'hF, 2'b01, 32'h100 + k, 0);
         if (k % 3 == 0) chk("rr_grant", req_ready, 64'(1) << ((k / 3) % 4));
      end
      for (int c = 0; c < 1500; c++) begin
         for (int i = 0; i < N; i++) begin
            if (hv[i] && last_ready[i]) hv[i] = 0;
            else if (hv[i]) begin
               if ($urandom_range(0, 3) == 0) hv[i] = 0;
            end else if ($urandom_range(0, 1) == 1) begin
               hv[i] = 1;
               hop[i] = 2'($urandom_range(0, 3));
               hd[i] = DW'($urandom_range(0, 255));
            end
            sop[2*i +: 2] = hop[i];
            sd[DW*i +: DW] = hd[i];
         end
         sv = hv;
         sfull = $urandom_range(0, 7) == 0;
         step();
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
